// File: rtl/amp_adc_sequencer.sv
// rtl/amp_adc_sequencer.sv - preamp gain programming and periodic ADC acquisition scheduler
// Gain programming always takes priority over a pending sample; lost ticks and missing dones are sticky.
module amp_adc_sequencer #(
   parameter int SAMPLE_DIV = 50000,
   parameter int TIMEOUT    = 4096
) (
   input  logic        CLK50MHZ,
   input  logic        RST,
   input  logic        gain_req,
   input  logic [3:0]  gain_a,
   input  logic [3:0]  gain_b,
   input  logic        enable,
   output logic        amp_trig,
   output logic [3:0]  amp_a,
   output logic [3:0]  amp_b,
   input  logic        amp_done,
   output logic        adc_trig,
   input  logic        adc_done,
   input  logic [13:0] adc_a,
   input  logic [13:0] adc_b,
   output logic [13:0] sample_a,
   output logic [13:0] sample_b,
   output logic        sample_valid,
   output logic        busy,
   output logic        overrun,
   output logic        timeout
);
   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] RELOAD = TW'(SAMPLE_DIV - 1);

   typedef enum logic [2:0] {IDLE, AMP_GO, AMP_WAIT, ADC_GO, ADC_WAIT} state_t;

   state_t        state, state_next;
   logic [TW-1:0] timer;
   logic [WW-1:0] wait_cnt;
   logic [3:0]    shadow_a, shadow_b;
   logic          gain_pend, samp_pend;
   logic          tick, wait_expire;

   assign tick        = enable && (timer == '0);
   assign wait_expire = (wait_cnt == WW'(TIMEOUT - 1));
   assign busy        = (state != IDLE);

   always_comb begin
      state_next = state;
      amp_trig   = 1'b0;
      adc_trig   = 1'b0;
      case (state)
         IDLE: begin
            if (gain_pend)      state_next = AMP_GO;
            else if (samp_pend) state_next = ADC_GO;
         end
         AMP_GO: begin
            amp_trig   = 1'b1;
            state_next = AMP_WAIT;
         end
         AMP_WAIT: begin
            if (amp_done || wait_expire) state_next = IDLE;
         end
         ADC_GO: begin
            adc_trig   = 1'b1;
            state_next = ADC_WAIT;
         end
         ADC_WAIT: begin
            if (adc_done || wait_expire) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         timer        <= RELOAD;
         wait_cnt     <= '0;
         shadow_a     <= 4'd1;
         shadow_b     <= 4'd1;
         gain_pend    <= 1'b1;
         samp_pend    <= 1'b0;
         amp_a        <= 4'd1;
         amp_b        <= 4'd1;
         sample_a     <= '0;
         sample_b     <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state <= state_next;

         if (!enable || tick) timer <= RELOAD;
         else                 timer <= timer - TW'(1);

         if (!enable)                samp_pend <= 1'b0;
         else if (tick)              samp_pend <= 1'b1;
         else if (state == ADC_GO)   samp_pend <= 1'b0;

         // A tick landing on ADC_GO is not a loss: that pending request is being served now.
         if (tick && samp_pend && state != ADC_GO) overrun <= 1'b1;

         if (gain_req) begin
            shadow_a  <= gain_a;
            shadow_b  <= gain_b;
            gain_pend <= 1'b1;
         end else if (state == AMP_GO) begin
            gain_pend <= 1'b0;
         end

         // Codes are presented together with amp_trig; a same-cycle request is forwarded directly.
         if (state == IDLE && gain_pend) begin
            amp_a <= gain_req ? gain_a : shadow_a;
            amp_b <= gain_req ? gain_b : shadow_b;
         end

         if (state == AMP_GO || state == ADC_GO)         wait_cnt <= '0;
         else if (state == AMP_WAIT || state == ADC_WAIT) wait_cnt <= wait_cnt + WW'(1);

         if ((state == AMP_WAIT && !amp_done && wait_expire) ||
             (state == ADC_WAIT && !adc_done && wait_expire))
            timeout <= 1'b1;

         sample_valid <= 1'b0;
         if (state == ADC_WAIT && adc_done) begin
            sample_a     <= adc_a;
            sample_b     <= adc_b;
            sample_valid <= 1'b1;
         end
      end
   end
endmodule
